// File: rtl/add_seq_mul.sv
// Clocked shift-add multiplier that drives a self-timed N-bit adder over a req/fin handshake.
// Optional ADD_TIMEOUT_EN bounds every wait state to TIMEOUT_CYC cycles and reports err with done.
module add_seq_mul #(
   parameter int N           = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] product,
   output logic           err,
   output logic           add_req,
   input  logic           add_fin,
   output logic           add_cin,
   output logic [N-1:0]   add_x,
   output logic [N-1:0]   add_y,
   input  logic [N-1:0]   add_so,
   input  logic           add_couto
);

   localparam int CW = $clog2(N + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_ITER, S_WAIT_LO, S_WAIT_HI, S_SHIFT, S_DONE
   } state_t;

   state_t          state;
   logic            fin_q1, fin_s;
   logic [N-1:0]    mcand, mq, hi;
   logic            c;
   logic [CW-1:0]   cnt;

   assign add_cin = 1'b0;
   assign add_x   = hi;
   assign add_y   = mcand;

   // The adder idles with fin high, so the synchronizer resets to that level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fin_q1 <= 1'b1;
         fin_s  <= 1'b1;
      end else begin
         fin_q1 <= add_fin;
         fin_s  <= fin_q1;
      end
   end

`ifdef ADD_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT_CYC + 1);
   logic [WW-1:0] wait_cnt;
   logic          err_q;
   logic          tmo;

   // wait_cnt counts cycles already spent in the state, so this caps the stay at TIMEOUT_CYC.
   assign tmo = (wait_cnt == WW'(TIMEOUT_CYC - 1));
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   // NOTE: all state is updated with non-blocking assignments so every branch sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         mcand   <= '0;
         mq      <= '0;
         hi      <= '0;
         c       <= 1'b0;
         cnt     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
         add_req <= 1'b0;
`ifdef ADD_TIMEOUT_EN
         wait_cnt <= '0;
         err_q    <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
`ifdef ADD_TIMEOUT_EN
         if (state == S_LOAD || state == S_WAIT_LO || state == S_WAIT_HI)
            wait_cnt <= wait_cnt + 1'b1;
         else
            wait_cnt <= '0;
`endif
         case (state)
            S_IDLE: begin
               if (start) begin
                  mcand <= a;
                  mq    <= b;
                  hi    <= '0;
                  c     <= 1'b0;
                  cnt   <= '0;
                  busy  <= 1'b1;
`ifdef ADD_TIMEOUT_EN
                  err_q <= 1'b0;
`endif
                  state <= S_LOAD;
               end
            end

            // Drains any adder operation left in flight from before a reset.
            S_LOAD: begin
               if (fin_s)
                  state <= S_ITER;
`ifdef ADD_TIMEOUT_EN
               else if (tmo) begin
                  product <= '0;
                  err_q   <= 1'b1;
                  done    <= 1'b1;
                  state   <= S_DONE;
               end
`endif
            end

            S_ITER: begin
               if (cnt == CW'(N)) begin
                  product <= {hi, mq};
                  done    <= 1'b1;
                  state   <= S_DONE;
               end else if (mq[0]) begin
                  add_req <= 1'b1;
                  state   <= S_WAIT_LO;
               end else begin
                  c     <= 1'b0;
                  state <= S_SHIFT;
               end
            end

            S_WAIT_LO: begin
               if (!fin_s) begin
                  add_req <= 1'b0;
                  state   <= S_WAIT_HI;
`ifdef ADD_TIMEOUT_EN
                  wait_cnt <= '0;
`endif
               end
`ifdef ADD_TIMEOUT_EN
               else if (tmo) begin
                  add_req <= 1'b0;
                  product <= '0;
                  err_q   <= 1'b1;
                  done    <= 1'b1;
                  state   <= S_DONE;
               end
`endif
            end

            // Sum and carry have been stable since before fin rose.
            S_WAIT_HI: begin
               if (fin_s) begin
                  hi    <= add_so;
                  c     <= add_couto;
                  state <= S_SHIFT;
               end
`ifdef ADD_TIMEOUT_EN
               else if (tmo) begin
                  product <= '0;
                  err_q   <= 1'b1;
                  done    <= 1'b1;
                  state   <= S_DONE;
               end
`endif
            end

            S_SHIFT: begin
               {c, hi, mq} <= {1'b0, c, hi, mq[N-1:1]};
               cnt         <= cnt + 1'b1;
               state       <= S_ITER;
            end

            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_add_seq_mul.sv
// Directed bench for add_seq_mul with a behavioural self-timed adder (10 ns response).
module tb_add_seq_mul;
   localparam int N = 32;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           start;
   logic [N-1:0]   a, b;
   logic           busy, done, err;
   logic [2*N-1:0] product;
   logic           add_req, add_fin, add_cin, add_couto;
   logic [N-1:0]   add_x, add_y, add_so;

   logic           fin_m = 1'b1;
   logic           fin_stuck = 1'b0;
   int             total = 0;
   int             bad = 0;
   int             req_rises = 0;
   int             bad_rises = 0;
   int             done_cnt = 0;

   always #5 clk = ~clk;

   add_seq_mul #(.N(N), .TIMEOUT_CYC(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .product(product), .err(err),
      .add_req(add_req), .add_fin(add_fin), .add_cin(add_cin),
      .add_x(add_x), .add_y(add_y), .add_so(add_so), .add_couto(add_couto)
   );

   // Four-phase adder: fin falls with a valid sum after req rises, returns high after req falls.
   assign add_fin = fin_m & ~fin_stuck;

   always @(posedge add_req) begin
      if (add_fin !== 1'b1) bad_rises++;
      req_rises++;
      #10;
      {add_couto, add_so} = {1'b0, add_x} + {1'b0, add_y} + {{N{1'b0}}, add_cin};
      fin_m = 1'b0;
   end

   always @(negedge add_req) begin
      #10;
      fin_m = 1'b1;
   end

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issues one start pulse and returns the edges from start sampling to done (bounded).
   task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tbv,
                         output logic [2*N-1:0] p, output int cyc);
      @(negedge clk);
      a = ta; b = tbv; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (done !== 1'b1 && cyc < 4000) begin
         @(negedge clk);
         cyc++;
      end
      check("done_seen", {63'd0, done}, 64'd1);
      p = product;
   endtask

   initial begin
      logic [2*N-1:0] p;
      int             cyc;

      add_so = '0; add_couto = 1'b0;
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
      #1;
      check("rst_busy",    {63'd0, busy},    64'd0);
      check("rst_done",    {63'd0, done},    64'd0);
      check("rst_err",     {63'd0, err},     64'd0);
      check("rst_product", product,          64'd0);
      check("rst_req",     {63'd0, add_req}, 64'd0);
      check("rst_x",       {32'd0, add_x},   64'd0);
      check("rst_y",       {32'd0, add_y},   64'd0);
      check("cin_zero",    {63'd0, add_cin}, 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // 3 * 5: two set multiplier bits, one done pulse
      req_rises = 0; done_cnt = 0;
      run_op(32'd3, 32'd5, p, cyc);
      check("p_3x5",     p,                64'd15);
      check("err_3x5",   {63'd0, err},     64'd0);
      check("req_3x5",   64'(req_rises),   64'd2);
      @(negedge clk); #1;
      check("done_pulse", {63'd0, done},   64'd0);
      check("busy_drop",  {63'd0, busy},   64'd0);
      check("done_cnt",   64'(done_cnt),   64'd1);

      // all-ones squared
      req_rises = 0; bad_rises = 0;
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, p, cyc);
      check("p_max",     p,                64'hFFFF_FFFE_0000_0001);
      check("req_max",   64'(req_rises),   64'd32);
      check("req_clean", 64'(bad_rises),   64'd0);

      // zero multiplier: no adder traffic, fixed latency 2N+3
      req_rises = 0;
      run_op(32'h1234, 32'd0, p, cyc);
      check("p_zero",    p,                64'd0);
      check("req_zero",  64'(req_rises),   64'd0);
      check("lat_zero",  64'(cyc),         64'd67);

      // second start while busy is ignored
      @(negedge clk);
      a = 32'd6; b = 32'd11; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      check("busy_mid",  {63'd0, busy},    64'd1);
      a = 32'd7; b = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (done !== 1'b1 && cyc < 4000) begin
         @(negedge clk);
         cyc++;
      end
      check("done_busy", {63'd0, done},    64'd1);
      check("p_ignore",  product,          64'd66);
      run_op(32'd7, 32'd7, p, cyc);
      check("p_7x7",     p,                64'd49);

      // reset while in WAIT_HI
      @(negedge clk);
      a = 32'd5; b = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (!(add_req === 1'b0 && fin_m === 1'b0) && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("reach_wait_hi", {63'd0, (cyc < 200)}, 64'd1);
      check("busy_pre_rst",  {63'd0, busy},        64'd1);
      #1 rst_n = 1'b0;
      #1;
      check("arst_busy",    {63'd0, busy},    64'd0);
      check("arst_req",     {63'd0, add_req}, 64'd0);
      check("arst_product", product,          64'd0);
      check("arst_x",       {32'd0, add_x},   64'd0);
      check("arst_y",       {32'd0, add_y},   64'd0);
      check("arst_done",    {63'd0, done},    64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      run_op(32'd2, 32'd9, p, cyc);
      check("p_after_rst", p, 64'd18);

`ifdef ADD_TIMEOUT_EN
      // fin stuck low after the adder acknowledges: WAIT_HI times out
      @(negedge clk);
      a = 32'd3; b = 32'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (add_req !== 1'b1 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      fin_stuck = 1'b1;
      cyc = 0;
      while (done !== 1'b1 && cyc < 60) begin
         @(negedge clk);
         cyc++;
      end
      check("tmo_done",    {63'd0, done},          64'd1);
      check("tmo_err",     {63'd0, err},           64'd1);
      check("tmo_product", product,                64'd0);
      check("tmo_req",     {63'd0, add_req},       64'd0);
      check("tmo_lat",     {63'd0, (cyc <= 24)},   64'd1);
      fin_stuck = 1'b0;
      repeat (5) @(negedge clk);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
